// File: rtl/vga_sync_gen_if.sv
// Timing bundle between the VGA sync generator and the character/font address stage.
interface vga_sync_gen_if;
  logic       ce;
  logic [9:0] hc;
  logic [9:0] vc;
  logic       hsync;
  logic       vsync;
  logic       vidon;
  logic       line_tick;
  logic       frame_tick;
  logic       blink;

  modport master (
    input  ce,
    output hc, vc, hsync, vsync, vidon, line_tick, frame_tick, blink
  );

  modport slave (
    output ce,
    input  hc, vc, hsync, vsync, vidon, line_tick, frame_tick, blink
  );
endinterface

// File: rtl/vga_sync_gen.sv
// 640x480@60Hz VGA timing generator on the 25 MHz pixel clock: counters, syncs,
// visible-window flag, line/frame ticks and a frame-based cursor blink.
module vga_sync_gen #(
  parameter int unsigned HTOTAL   = 800,
  parameter int unsigned VTOTAL   = 521,
  parameter int unsigned HSP      = 96,
  parameter int unsigned VSP      = 2,
  parameter int unsigned HBP      = 144,
  parameter int unsigned HFP      = 784,
  parameter int unsigned VBP      = 31,
  parameter int unsigned VFP      = 511,
  parameter int unsigned BLINK_FR = 30
) (
  input  logic           clk25,
  input  logic           clr,
  vga_sync_gen_if.master bus
);

  localparam logic [9:0] H_LAST  = 10'(HTOTAL - 1);
  localparam logic [9:0] V_LAST  = 10'(VTOTAL - 1);
  localparam logic [9:0] H_SP    = 10'(HSP);
  localparam logic [9:0] V_SP    = 10'(VSP);
  localparam logic [9:0] H_BP    = 10'(HBP);
  localparam logic [9:0] H_FP    = 10'(HFP);
  localparam logic [9:0] V_BP    = 10'(VBP);
  localparam logic [9:0] V_FP    = 10'(VFP);
  localparam logic [5:0] BF_LAST = 6'(BLINK_FR - 1);

  logic [9:0] hc_q, hc_d;
  logic [9:0] vc_q, vc_d;
  logic [5:0] frm_q, frm_d;
  logic       blink_q, blink_d;
  logic       line_end_s;
  logic       frame_end_s;

  assign line_end_s  = (hc_q == H_LAST);
  assign frame_end_s = line_end_s && (vc_q == V_LAST);

  // Next-state for counters, frame count and blink; ce=0 holds everything.
  always_comb begin
    hc_d    = hc_q;
    vc_d    = vc_q;
    frm_d   = frm_q;
    blink_d = blink_q;
    if (bus.ce) begin
      if (line_end_s) begin
        hc_d = 10'd0;
        if (vc_q == V_LAST) begin
          vc_d = 10'd0;
        end else begin
          vc_d = vc_q + 10'd1;
        end
      end else begin
        hc_d = hc_q + 10'd1;
      end
      if (frame_end_s) begin
        if (frm_q == BF_LAST) begin
          frm_d   = 6'd0;
          blink_d = ~blink_q;
        end else begin
          frm_d = frm_q + 6'd1;
        end
      end else begin
        frm_d = frm_q;
      end
    end else begin
      hc_d = hc_q;
    end
  end

  // State register; clr wins over ce and restarts at (0,0) immediately.
  always_ff @(posedge clk25) begin
    if (clr) begin
      hc_q    <= 10'd0;
      vc_q    <= 10'd0;
      frm_q   <= 6'd0;
      blink_q <= 1'b0;
    end else begin
      hc_q    <= hc_d;
      vc_q    <= vc_d;
      frm_q   <= frm_d;
      blink_q <= blink_d;
    end
  end

  // Decodes are zero-latency so hc/vc/vidon stay aligned for the pixel stage.
  assign bus.hc         = hc_q;
  assign bus.vc         = vc_q;
  assign bus.hsync      = ~(hc_q < H_SP);
  assign bus.vsync      = ~(vc_q < V_SP);
  assign bus.vidon      = (hc_q >= H_BP) && (hc_q < H_FP) && (vc_q >= V_BP) && (vc_q < V_FP);
  assign bus.line_tick  = line_end_s;
  assign bus.frame_tick = frame_end_s;
  assign bus.blink      = blink_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Randomized bench for vga_sync_gen: a full-size instance over its first lines and a
// shrunken-timing instance over many frames, both against an enabled-clock-count model.
module tb_vga_sync_gen;

  localparam int S_HT = 20, S_VT = 12, S_HSP = 3, S_VSP = 2, S_HBP = 5, S_HFP = 17;
  localparam int S_VBP = 3, S_VFP = 10, S_BF = 2;

  logic clk = 1'b0;
  logic clr_full, clr_small;
  int   checks = 0;
  int   fails  = 0;
  int   n_full = 0;
  int   n_small = 0;

  vga_sync_gen_if fif ();
  vga_sync_gen_if sif ();

  vga_sync_gen u_full (.clk25(clk), .clr(clr_full), .bus(fif));

  vga_sync_gen #(
    .HTOTAL(S_HT), .VTOTAL(S_VT), .HSP(S_HSP), .VSP(S_VSP), .HBP(S_HBP),
    .HFP(S_HFP), .VBP(S_VBP), .VFP(S_VFP), .BLINK_FR(S_BF)
  ) u_small (.clk25(clk), .clr(clr_small), .bus(sif));

  always #20 clk = ~clk;

  task automatic check_eq(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // The model: n enabled edges since reset fully determine every output.
  task automatic check_model(input string p, input int n, input int ht, input int vt,
                             input int hsp, input int vsp, input int hbp, input int hfp,
                             input int vbp, input int vfp, input int bf,
                             input int hc, input int vc, input int hs, input int vs,
                             input int vid, input int lt, input int ft, input int bl);
    int h, v, f;
    h = n % ht;
    v = (n / ht) % vt;
    f = n / (ht * vt);
    check_eq({p, "hc"}, hc, h);
    check_eq({p, "vc"}, vc, v);
    check_eq({p, "hsync"}, hs, (h < hsp) ? 0 : 1);
    check_eq({p, "vsync"}, vs, (v < vsp) ? 0 : 1);
    check_eq({p, "vidon"}, vid, (h >= hbp && h < hfp && v >= vbp && v < vfp) ? 1 : 0);
    check_eq({p, "line_tick"}, lt, (h == ht - 1) ? 1 : 0);
    check_eq({p, "frame_tick"}, ft, (h == ht - 1 && v == vt - 1) ? 1 : 0);
    check_eq({p, "blink"}, bl, (f / bf) % 2);
  endtask

  task automatic step_full(input logic r, input logic e);
    clr_full = r;
    fif.ce   = e;
    @(posedge clk);
    if (r) n_full = 0;
    else if (e) n_full++;
    @(negedge clk);
    check_model("full.", n_full, 800, 521, 96, 2, 144, 784, 31, 511, 30,
                int'(fif.hc), int'(fif.vc), int'(fif.hsync), int'(fif.vsync),
                int'(fif.vidon), int'(fif.line_tick), int'(fif.frame_tick), int'(fif.blink));
  endtask

  task automatic step_small(input logic r, input logic e);
    clr_small = r;
    sif.ce    = e;
    @(posedge clk);
    if (r) n_small = 0;
    else if (e) n_small++;
    @(negedge clk);
    check_model("small.", n_small, S_HT, S_VT, S_HSP, S_VSP, S_HBP, S_HFP, S_VBP, S_VFP, S_BF,
                int'(sif.hc), int'(sif.vc), int'(sif.hsync), int'(sif.vsync),
                int'(sif.vidon), int'(sif.line_tick), int'(sif.frame_tick), int'(sif.blink));
  endtask

  initial begin
    int vid_cnt, ft_cnt, fr;
    int blink_exp [5] = '{0, 0, 1, 1, 0};

    clr_full  = 1'b1;
    clr_small = 1'b1;
    fif.ce    = 1'b0;
    sif.ce    = 1'b0;

    // Reset state, then free-run the full-size timing across several lines.
    step_full(1'b1, 1'b0);
    step_full(1'b1, 1'b1);
    for (int i = 0; i < 3 * 800 + 400; i++) step_full(1'b0, 1'b1);
    check_eq("full.pre_reset_hc", int'(fif.hc), 400);
    check_eq("full.pre_reset_vc", int'(fif.vc), 3);
    for (int i = 0; i < 3; i++) step_full(1'b1, 1'b1);
    for (int i = 0; i < 900; i++) step_full(1'b0, 1'b1);
    for (int i = 0; i < 600; i++) step_full(1'b0, ($urandom_range(0, 3) != 0));

    // Shrunken timing: random ce with occasional resets over many frames.
    for (int i = 0; i < 3000; i++) begin
      step_small(($urandom_range(0, 399) == 0), ($urandom_range(0, 3) != 0));
    end

    // Freeze on the last clock of a frame, then release.
    while ((n_small % (S_HT * S_VT)) != (S_HT * S_VT - 1)) step_small(1'b0, 1'b1);
    for (int i = 0; i < 50; i++) begin
      step_small(1'b0, 1'b0);
      check_eq("freeze.frame_tick", int'(sif.frame_tick), 1);
    end
    step_small(1'b0, 1'b1);
    check_eq("release.hc", int'(sif.hc), 0);
    check_eq("release.vc", int'(sif.vc), 0);

    // One complete frame from (0,0): visible clocks and frame ticks per frame.
    vid_cnt = 0;
    ft_cnt  = 0;
    for (int i = 0; i < S_HT * S_VT; i++) begin
      step_small(1'b0, 1'b1);
      vid_cnt += int'(sif.vidon);
      ft_cnt  += int'(sif.frame_tick);
    end
    check_eq("frame.vidon_clocks", vid_cnt, (S_HFP - S_HBP) * (S_VFP - S_VBP));
    check_eq("frame.tick_count", ft_cnt, 1);

    // Blink sequence over five frames from reset with a two-frame half-period.
    step_small(1'b1, 1'b0);
    fr = 0;
    for (int i = 0; i < 5 * S_HT * S_VT + 4 && fr < 5; i++) begin
      step_small(1'b0, 1'b1);
      if (sif.frame_tick) begin
        check_eq($sformatf("blink.frame%0d", fr + 1), int'(sif.blink), blink_exp[fr]);
        fr++;
      end
    end
    check_eq("blink.frames_seen", fr, 5);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
